key_load_stage: RTL and testbench

- Upstream feeder for the locked c499 SEC core.
- Receives the 47-bit unlock key serially: 43 XOR key-gate bits (X_1..X_43) and 4 MUX4 select bits (p1..p4).
- Checks the key with a trailing even-parity bit, commits it into an active key register, and drives it to the core.
- Also registers the 41-bit primary-input word and holds it at zero while no valid key is committed.

---
 rtl/key_load_stage.sv | 194 +++++++++++++++++++
 tb/tb_key_load_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_load_stage.sv
`default_nettype none
// ============================================================================
//  Module   : key_load_stage
//  Brief    : Serial unlock-key loader for the locked c499 SEC core.
//             Shifts in a 47-bit key LSB-first (43 XOR gate bits followed by
//             4 MUX4 select bits), verifies a trailing even-parity bit,
//             commits the key to the active key register and gates the
//             primary-input word to the core until a key is committed.
//  Options  : KEY_LOCK_EN - when defined, a committed key cannot be
//             replaced until rst; when undefined, key_start in ACTIVE
//             begins a fresh load.
//  Revision : 1.0 - initial release
// ============================================================================
module key_load_stage #(
    parameter int XKEY_W = 43,
    parameter int PKEY_W = 4,
    parameter int DATA_W = 41
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_start,
    input  logic              key_sin,
    input  logic              key_sin_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic [XKEY_W-1:0] key_x,
    output logic [PKEY_W-1:0] key_p,
    output logic              key_valid,
    output logic              load_err,
    output logic              busy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
);

    localparam int c_key_w = XKEY_W + PKEY_W;
    localparam int c_cnt_w = $clog2(c_key_w);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(c_key_w - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic [c_key_w-1:0]  r_shadow;
    logic [c_key_w-1:0]  w_shadow_next;
    logic [XKEY_W-1:0]   r_key_x;
    logic [XKEY_W-1:0]   w_key_x_next;
    logic [PKEY_W-1:0]   r_key_p;
    logic [PKEY_W-1:0]   w_key_p_next;
    logic                r_key_valid;
    logic                w_key_valid_next;
    logic                r_load_err;
    logic                w_load_err_next;
    logic                w_start_load;
    logic                w_parity_ok;
    logic [DATA_W-1:0]   r_dout;
    logic                r_dout_valid;

    // Even parity over the shadow key plus the incoming parity bit.
    assign w_parity_ok = ~(^r_shadow ^ key_sin);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus next values of the counter, shadow and key registers.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_shadow_next    = r_shadow;
        w_key_x_next     = r_key_x;
        w_key_p_next     = r_key_p;
        w_key_valid_next = r_key_valid;
        w_load_err_next  = r_load_err;
        w_start_load     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (key_start) begin
                    w_start_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                // A restart takes priority over a bit arriving in the same cycle.
                if (key_start) begin
                    w_start_load = 1'b1;
                end else if (key_sin_valid) begin
                    w_shadow_next[r_cnt] = key_sin;
                    w_cnt_next           = r_cnt + 1'b1;
                    if (r_cnt == c_last_bit) begin
                        w_state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (key_start) begin
                    w_start_load = 1'b1;
                end else if (key_sin_valid) begin
                    if (w_parity_ok) begin
                        w_state_next     = ST_ACTIVE;
                        w_key_x_next     = r_shadow[XKEY_W-1:0];
                        w_key_p_next     = r_shadow[c_key_w-1:XKEY_W];
                        w_key_valid_next = 1'b1;
                        w_load_err_next  = 1'b0;
                    end else begin
                        w_state_next     = ST_ERROR;
                        w_load_err_next  = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
`ifdef KEY_LOCK_EN
                // Committed key is frozen until reset.
                w_state_next = ST_ACTIVE;
`else
                if (key_start) begin
                    w_start_load = 1'b1;
                end
`endif
            end
            ST_ERROR: begin
                if (key_start) begin
                    w_start_load = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Entering SHIFT wipes the old key so the core never sees a partial one.
        if (w_start_load) begin
            w_state_next     = ST_SHIFT;
            w_cnt_next       = '0;
            w_shadow_next    = '0;
            w_key_x_next     = '0;
            w_key_p_next     = '0;
            w_key_valid_next = 1'b0;
            w_load_err_next  = 1'b0;
        end
    end

    // Key shift/commit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_key_x     <= '0;
            r_key_p     <= '0;
            r_key_valid <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_shadow    <= w_shadow_next;
            r_key_x     <= w_key_x_next;
            r_key_p     <= w_key_p_next;
            r_key_valid <= w_key_valid_next;
            r_load_err  <= w_load_err_next;
        end
    end

    // Data word register; words are forced to zero until a key is committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout       <= (din_valid && r_key_valid) ? din : '0;
            r_dout_valid <= din_valid & r_key_valid;
        end
    end

    assign key_x      = r_key_x;
    assign key_p      = r_key_p;
    assign key_valid  = r_key_valid;
    assign load_err   = r_load_err;
    assign busy       = (r_state == ST_SHIFT) || (r_state == ST_CHECK);
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_key_load_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_load_stage
//  Brief    : Self-checking bench for key_load_stage. Stimulus pushes the
//             expected key result / data word into queues; a monitor pops
//             and compares when a load finishes or dout_valid is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_load_stage;

    localparam int XKEY_W = 43;
    localparam int PKEY_W = 4;
    localparam int DATA_W = 41;

    logic              clk;
    logic              rst;
    logic              key_start;
    logic              key_sin;
    logic              key_sin_valid;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic [XKEY_W-1:0] key_x;
    logic [PKEY_W-1:0] key_p;
    logic              key_valid;
    logic              load_err;
    logic              busy;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;

    typedef struct packed {
        logic [XKEY_W-1:0] kx;
        logic [PKEY_W-1:0] kp;
        logic              kv;
        logic              err;
    } key_exp_t;

    key_exp_t          kq[$];
    logic [DATA_W-1:0] dq[$];

    int checks = 0;
    int errors = 0;

    logic r_busy_q = 1'b0;
    logic r_rst_q  = 1'b1;

    key_load_stage dut (
        .clk           (clk),
        .rst           (rst),
        .key_start     (key_start),
        .key_sin       (key_sin),
        .key_sin_valid (key_sin_valid),
        .din           (din),
        .din_valid     (din_valid),
        .key_x         (key_x),
        .key_p         (key_p),
        .key_valid     (key_valid),
        .load_err      (load_err),
        .busy          (busy),
        .dout          (dout),
        .dout_valid    (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: a load completes when busy falls outside reset; data when dout_valid.
    always @(negedge clk) begin
        key_exp_t e;
        logic [DATA_W-1:0] w;
        if (r_busy_q && !busy && !r_rst_q) begin
            if (kq.size() == 0) begin
                chk("unexpected_load_end", 64'(busy), 64'(1));
            end else begin
                e = kq.pop_front();
                chk("sb_key_x", 64'(key_x), 64'(e.kx));
                chk("sb_key_p", 64'(key_p), 64'(e.kp));
                chk("sb_key_valid", 64'(key_valid), 64'(e.kv));
                chk("sb_load_err", 64'(load_err), 64'(e.err));
            end
        end
        if (dout_valid) begin
            if (dq.size() == 0) begin
                chk("unexpected_dout_valid", 64'(dout_valid), 64'(0));
            end else begin
                w = dq.pop_front();
                chk("sb_dout", 64'(dout), 64'(w));
            end
        end else begin
            chk("dout_zero_when_invalid", 64'(dout), 64'(0));
        end
        r_busy_q <= busy;
        r_rst_q  <= rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        key_sin       = b;
        key_sin_valid = 1'b1;
        tick();
        key_sin_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic with_bit, input logic b);
        key_start     = 1'b1;
        key_sin_valid = with_bit;
        key_sin       = b;
        tick();
        key_start     = 1'b0;
        key_sin_valid = 1'b0;
    endtask

    // Shift n key bits LSB-first with one idle cycle inserted after bit 5.
    task automatic shift_bits(input logic [46:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(k[i]);
            if (i == 5) tick();
        end
    endtask

    // Parity bit, with a data word presented on the same (commit) edge.
    task automatic send_parity(input logic p, input logic [DATA_W-1:0] w);
        din       = w;
        din_valid = 1'b1;
        send_bit(p);
        din_valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        key_exp_t e;
        logic [46:0] k55;
        logic [46:0] kones;
        k55   = 47'h5555_5555_5555;
        kones = '1;

        rst = 1'b1; key_start = 1'b0; key_sin = 1'b0; key_sin_valid = 1'b0;
        din = 41'h1_2345_6789; din_valid = 1'b1;
        tick(); tick();
        chk("rst_key_valid", 64'(key_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        tick();
        chk("idle_dout_valid", 64'(dout_valid), 64'(0));
        chk("idle_dout", 64'(dout), 64'(0));
        chk("idle_key_valid", 64'(key_valid), 64'(0));
        chk("idle_load_err", 64'(load_err), 64'(0));
        din_valid = 1'b0;
        tick();

        // Bad parity: 24 ones plus parity 1 is odd.
        pulse_start(1'b0, 1'b0);
        chk("shift_busy", 64'(busy), 64'(1));
        shift_bits(k55, 47);
        chk("check_busy", 64'(busy), 64'(1));
        e.kx = '0; e.kp = '0; e.kv = 1'b0; e.err = 1'b1;
        kq.push_back(e);
        send_parity(1'b1, 41'h0_0000_1111);
        tick();

        // Good load from ERROR: bits 43..46 of 0x5555... are 0,1,0,1 -> key_p = 4'hA.
        pulse_start(1'b0, 1'b0);
        chk("restart_clears_err", 64'(load_err), 64'(0));
        shift_bits(k55, 47);
        e.kx = 43'h555_5555_5555; e.kp = 4'hA; e.kv = 1'b1; e.err = 1'b0;
        kq.push_back(e);
        send_parity(1'b0, 41'h1_0BAD_F00D);
        chk("good_busy", 64'(busy), 64'(0));
        tick();

        // Data pass, back-to-back words.
        din = 41'h0_DEAD_BEEF; din_valid = 1'b1; dq.push_back(41'h0_DEAD_BEEF);
        tick();
        din = 41'h1_FFFF_0001; dq.push_back(41'h1_FFFF_0001);
        tick();
        din_valid = 1'b0;
        tick();

        // Reset clears a committed key.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_clears_key_x", 64'(key_x), 64'(0));
        chk("rst_clears_key_valid", 64'(key_valid), 64'(0));

        // Reset in the middle of a load.
        pulse_start(1'b0, 1'b0);
        shift_bits(kones, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midload_rst_busy", 64'(busy), 64'(0));
        tick();

        // Restart mid-load; the 0 bit under the second key_start is dropped.
        pulse_start(1'b0, 1'b0);
        shift_bits(kones, 20);
        pulse_start(1'b1, 1'b0);
        chk("restart_busy", 64'(busy), 64'(1));
        shift_bits(kones, 47);
        e.kx = '1; e.kp = 4'hF; e.kv = 1'b1; e.err = 1'b0;
        kq.push_back(e);
        send_parity(1'b1, 41'h0_1234_5678);
        tick();

        din = 41'h0_DEAD_BEEF; din_valid = 1'b1; dq.push_back(41'h0_DEAD_BEEF);
        tick();
        din_valid = 1'b0;
        tick();

        // Relock attempt; bits after it are ignored or shifted depending on mode.
        pulse_start(1'b0, 1'b0);
`ifdef KEY_LOCK_EN
        chk("relock_key_valid", 64'(key_valid), 64'(1));
        chk("relock_busy", 64'(busy), 64'(0));
        send_bit(1'b0);
        chk("relock_key_x", 64'(key_x), 64'({XKEY_W{1'b1}}));
`else
        chk("relock_key_valid", 64'(key_valid), 64'(0));
        chk("relock_busy", 64'(busy), 64'(1));
        chk("relock_key_x", 64'(key_x), 64'(0));
`endif
        tick(); tick();
        chk("key_queue_drained", 64'(kq.size()), 64'(0));
        chk("data_queue_drained", 64'(dq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
